nf10_xgmac_tx_emulator: RTL and testbench
=========================================

# nf10_xgmac_tx_emulator

Synthesizable stand-in for the 10G MAC's transmit client interface, with loopback onto the MAC receive client interface. It accepts frames from `tx_queue` using the MAC's start/ack handshake. Each accepted word is forwarded unchanged to the `rx_*` client signals feeding `rx_queue`, and a good or bad status is issued per frame. Used for XAUI-less loopback bring-up and for regressions of the AXI queues.

## Interface
Parameters:
- `C_ACK_DELAY`, default 3: cycles from `tx_start` being sampled high in IDLE to `tx_ack`. Legal range 1..15.
- `C_IFG_CYCLES`, default 2: idle cycles after a status pulse before a new `tx_start` is sampled. Legal range 0..15.
- `C_MIN_LEN`, default 60: minimum legal frame length in bytes.
- `C_MAX_LEN`, default 1514: maximum legal frame length in bytes.

Ports:
- `axi_aclk`, in, 1: single clock for the whole block.
- `axi_resetn`, in, 1: asynchronous, active-low reset.
- `tx_data`, in, 64: transmit word; byte 0 is bits [7:0].
- `tx_data_valid`, in, 8: per-byte valid for `tx_data`.
- `tx_start`, in, 1: frame request. Held high with the first word stable until `tx_ack`.
- `tx_ack`, out, 1: one-cycle accept pulse. The first word is captured in this cycle.
- `rx_data`, out, 64: looped-back word.
- `rx_data_valid`, out, 8: looped-back byte valids.
- `rx_good_frame`, out, 1: one-cycle status pulse for a good frame.
- `rx_bad_frame`, out, 1: one-cycle status pulse for a bad frame.
- `stat_frames`, out, 32: count of frames completed, good and bad. Saturates.
- `stat_bad_frames`, out, 32: count of bad frames. Saturates.

## Operation
States and transitions:
- IDLE → ACK_WAIT when `tx_start` is sampled high.
- ACK_WAIT counts `C_ACK_DELAY` cycles, then drives `tx_ack` for one cycle and captures word 0. → DATA.
- DATA: the client must present one word per cycle with no gaps. The terminating cycle T is the first cycle after `tx_ack` in which `tx_data_valid != 8'hFF`.
  - Valid at T = 0: the previous word was the last word.
  - Valid at T is a contiguous-from-LSB pattern (8'h01, 8'h03, … 8'h7F): the word at T is the last word and is forwarded.
  - Any other pattern at T (e.g. 8'h05): that word is forwarded as-is, treated as the last word, and the frame is marked bad.
  - From DATA → STATUS.
- STATUS: pulses exactly one of `rx_good_frame` or `rx_bad_frame`. → IFG, or → IDLE if `C_IFG_CYCLES` = 0.
- IFG counts `C_IFG_CYCLES` cycles, then → IDLE. `tx_start` is ignored in STATUS and IFG.

Length and status rules:
- Byte count = 8 × (full words) + popcount of the last word's valid. Counted in a 16-bit counter that saturates at 16'hFFFF.
- A frame is bad if length < `C_MIN_LEN`, length > `C_MAX_LEN`, or the valid pattern is invalid. Otherwise it is good.
- Bad frames are still forwarded in full.
- `tx_start` high in DATA after the `tx_ack` cycle is a protocol violation: the frame is marked bad and the start is not re-acknowledged.

Reset:
- All outputs reset to 0 and state returns to IDLE.
- `axi_resetn` asserted mid-frame aborts the frame with no status pulse and no counter update.

## Timing
- `tx_ack` rises exactly `C_ACK_DELAY` cycles after the cycle in which `tx_start` is first sampled high in IDLE.
- `rx_data` and `rx_data_valid` are `tx_data` and `tx_data_valid` registered, with 1-cycle latency. Word 0 appears the cycle after `tx_ack`.
- Outside frames, `rx_data_valid` = 0 and `rx_data` = 0.
- The status pulse occurs exactly 1 cycle after the last forwarded rx word, with `rx_data_valid` = 0 in that cycle.
- The next `tx_ack` occurs no earlier than status cycle + 1 + `C_IFG_CYCLES` + `C_ACK_DELAY`.
- Statistics update in the cycle after the status pulse.
- Statistics counters hold at 32'hFFFFFFFF; they never wrap.

## Configuration
- `NF10_XGMAC_EMU_STATS_EN` defined: `stat_frames` and `stat_bad_frames` counters are implemented as described above.
- Not defined: both ports remain and are tied to 0, and no counter logic is synthesized.
- Handshake and loopback behaviour are identical in both builds.

## Test plan
- 64-byte frame (8 words of 8'hFF, then 0) with `C_ACK_DELAY`=3 → `tx_ack` 3 cycles after `tx_start`; 8 rx words, each 1 cycle late; `rx_good_frame` 1 cycle after word 8; `stat_frames`=1.
- 61-byte frame (7 full words, last valid 8'h1F) → last rx valid = 8'h1F; `rx_good_frame` pulses; byte count = 61.
- 40-byte frame, and separately a 1600-byte frame → `rx_bad_frame` pulses for each with all words forwarded; `stat_bad_frames`=2.
- 64-byte frame whose 5th word has valid 8'h05 → frame ends at that word; `rx_bad_frame` pulses 1 cycle after it.
- Back-to-back frames with `tx_start` held high through IFG, `C_IFG_CYCLES`=2 → second `tx_ack` exactly status+1+2+3 cycles.
- `axi_resetn` pulsed low during word 4 → all outputs 0 immediately; no status pulse; counters 0; a following clean frame completes good.

Source files
------------

// File: rtl/nf10_xgmac_tx_emulator.sv
// Loopback stand-in for the 10G MAC transmit client: start/ack handshake, 1-cycle rx echo, per-frame status.
// Define NF10_XGMAC_EMU_STATS_EN to build the saturating stat_frames/stat_bad_frames counters.
module nf10_xgmac_tx_emulator #(
  parameter int unsigned C_ACK_DELAY  = 3,
  parameter int unsigned C_IFG_CYCLES = 2,
  parameter int unsigned C_MIN_LEN    = 60,
  parameter int unsigned C_MAX_LEN    = 1514
) (
  input  logic        axi_aclk,
  input  logic        axi_resetn,
  input  logic [63:0] tx_data,
  input  logic [7:0]  tx_data_valid,
  input  logic        tx_start,
  output logic        tx_ack,
  output logic [63:0] rx_data,
  output logic [7:0]  rx_data_valid,
  output logic        rx_good_frame,
  output logic        rx_bad_frame,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_bad_frames
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ACK_WAIT = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_STATUS   = 3'd4;
  localparam logic [2:0] S_IFG      = 3'd5;

  localparam logic [3:0]  ACK_DELAY  = 4'(C_ACK_DELAY);
  localparam logic [3:0]  IFG_CYCLES = 4'(C_IFG_CYCLES);
  localparam logic [15:0] MIN_LEN    = 16'(C_MIN_LEN);
  localparam logic [15:0] MAX_LEN    = 16'(C_MAX_LEN);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic        bad_q, bad_d;
  logic [63:0] rx_data_q, rx_data_d;
  logic [7:0]  rx_valid_q, rx_valid_d;

  logic        capture;
  logic        ack;
  logic [16:0] len_sum;
  logic [15:0] len_inc;
  logic        vld_full;
  logic        vld_zero;
  logic        vld_contig;
  logic        frame_bad;

  assign len_sum    = {1'b0, len_q} + {13'd0, popcount8(tx_data_valid)};
  assign len_inc    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign vld_full   = (tx_data_valid == 8'hFF);
  assign vld_zero   = (tx_data_valid == 8'h00);
  // A pattern is contiguous from the LSB exactly when adding one clears every set bit.
  assign vld_contig = ((tx_data_valid & (tx_data_valid + 8'd1)) == 8'd0);
  assign frame_bad  = bad_q | (len_q < MIN_LEN) | (len_q > MAX_LEN);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    bad_d      = bad_q;
    rx_data_d  = 64'd0;
    rx_valid_d = 8'd0;
    capture    = 1'b0;
    ack        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d = S_ACK_WAIT;
          cnt_d   = 4'd1;
          len_d   = 16'd0;
          bad_d   = 1'b0;
        end
      end
      S_ACK_WAIT: begin
        if (cnt_q == ACK_DELAY) begin
          ack     = 1'b1;
          capture = 1'b1;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DATA: begin
        if (tx_start) bad_d = 1'b1;
        if (vld_full) begin
          capture = 1'b1;
        end else if (vld_zero) begin
          state_d = S_STATUS;
        end else begin
          capture = 1'b1;
          state_d = S_DRAIN;
          if (!vld_contig) bad_d = 1'b1;
        end
      end
      // Lets the partial last word appear on rx before the status pulse.
      S_DRAIN: state_d = S_STATUS;
      S_STATUS: begin
        if (IFG_CYCLES == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IFG;
          cnt_d   = 4'd1;
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_CYCLES) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      rx_data_d  = tx_data;
      rx_valid_d = tx_data_valid;
      len_d      = len_inc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      len_q      <= 16'd0;
      bad_q      <= 1'b0;
      rx_data_q  <= 64'd0;
      rx_valid_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      bad_q      <= bad_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ack        = ack;
  assign rx_data       = rx_data_q;
  assign rx_data_valid = rx_valid_q;
  assign rx_good_frame = (state_q == S_STATUS) & ~frame_bad;
  assign rx_bad_frame  = (state_q == S_STATUS) &  frame_bad;

`ifdef NF10_XGMAC_EMU_STATS_EN
  logic [31:0] frames_q;
  logic [31:0] bad_frames_q;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      frames_q     <= 32'd0;
      bad_frames_q <= 32'd0;
    end else if (state_q == S_STATUS) begin
      if (frames_q != 32'hFFFF_FFFF) frames_q <= frames_q + 32'd1;
      if (frame_bad && (bad_frames_q != 32'hFFFF_FFFF)) bad_frames_q <= bad_frames_q + 32'd1;
    end
  end

  assign stat_frames     = frames_q;
  assign stat_bad_frames = bad_frames_q;
`else
  assign stat_frames     = 32'd0;
  assign stat_bad_frames = 32'd0;
`endif

endmodule

// File: tb/tb_nf10_xgmac_tx_emulator.sv
// Directed bench for nf10_xgmac_tx_emulator: handshake latency, loopback words, status and counters.
module tb_nf10_xgmac_tx_emulator;

  localparam int ACK_DELAY  = 3;
  localparam int IFG_CYCLES = 2;
`ifdef NF10_XGMAC_EMU_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        axi_aclk = 1'b0;
  logic        axi_resetn;
  logic [63:0] tx_data;
  logic [7:0]  tx_data_valid;
  logic        tx_start;
  logic        tx_ack;
  logic [63:0] rx_data;
  logic [7:0]  rx_data_valid;
  logic        rx_good_frame;
  logic        rx_bad_frame;
  logic [31:0] stat_frames;
  logic [31:0] stat_bad_frames;

  int checks   = 0;
  int failures = 0;
  int seq      = 0;
  int n_frames = 0;
  int n_bad    = 0;

  nf10_xgmac_tx_emulator #(
    .C_ACK_DELAY (ACK_DELAY),
    .C_IFG_CYCLES(IFG_CYCLES),
    .C_MIN_LEN   (60),
    .C_MAX_LEN   (1514)
  ) dut (
    .axi_aclk       (axi_aclk),
    .axi_resetn     (axi_resetn),
    .tx_data        (tx_data),
    .tx_data_valid  (tx_data_valid),
    .tx_start       (tx_start),
    .tx_ack         (tx_ack),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_good_frame  (rx_good_frame),
    .rx_bad_frame   (rx_bad_frame),
    .stat_frames    (stat_frames),
    .stat_bad_frames(stat_bad_frames)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input int i);
    logic [15:0] s;
    s = seq[15:0];
    return {16'hC0DE, s, 32'(i)};
  endfunction

  function automatic logic [31:0] stat_exp(input int v);
    return STATS_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "/stat_frames"}, 64'(stat_frames), 64'(stat_exp(n_frames)));
    check({tag, "/stat_bad_frames"}, 64'(stat_bad_frames), 64'(stat_exp(n_bad)));
  endtask

  // Drives one frame of n_words words (last one with last_vld) and checks ack latency,
  // every looped-back word, the status pulse and the counters.
  task automatic run_frame(input string tag, input int n_words, input logic [7:0] last_vld,
                           input logic exp_bad, input bit pre_started, input int exp_lat,
                           input bit viol, input bit hold_next);
    int lat;
    if (!pre_started) begin
      @(negedge axi_aclk);
      tx_start      = 1'b1;
      tx_data       = word(0);
      tx_data_valid = 8'hFF;
    end
    lat = 0;
    do begin
      @(negedge axi_aclk);
      lat++;
    end while (!tx_ack && lat < 32);
    check({tag, "/ack_latency"}, 64'(lat), 64'(exp_lat));
    if (!tx_ack) begin
      tx_start = 1'b0;
      return;
    end
    for (int i = 1; i < n_words; i++) begin
      @(negedge axi_aclk);
      if (i == 1) check({tag, "/ack_one_cycle"}, 64'(tx_ack), 64'd0);
      check({tag, "/rx_data"}, rx_data, word(i - 1));
      check({tag, "/rx_valid"}, 64'(rx_data_valid), 64'hFF);
      tx_start      = viol && (i == 1);
      tx_data       = word(i);
      tx_data_valid = (i == n_words - 1) ? last_vld : 8'hFF;
    end
    @(negedge axi_aclk);
    check({tag, "/last_rx_data"}, rx_data, word(n_words - 1));
    check({tag, "/last_rx_valid"}, 64'(rx_data_valid), 64'(last_vld));
    check({tag, "/no_early_status"}, 64'({rx_good_frame, rx_bad_frame}), 64'd0);
    tx_start      = 1'b0;
    tx_data       = 64'hDEAD_BEEF_DEAD_BEEF;
    tx_data_valid = 8'h00;
    @(negedge axi_aclk);
    check({tag, "/status"}, 64'({rx_good_frame, rx_bad_frame}), 64'({~exp_bad, exp_bad}));
    check({tag, "/status_rx_valid"}, 64'(rx_data_valid), 64'd0);
    check({tag, "/status_rx_data"}, rx_data, 64'd0);
    n_frames++;
    if (exp_bad) n_bad++;
    seq++;
    if (hold_next) begin
      tx_start      = 1'b1;
      tx_data       = word(0);
      tx_data_valid = 8'hFF;
      return;
    end
    tx_data = 64'd0;
    @(negedge axi_aclk);
    check({tag, "/status_one_cycle"}, 64'({rx_good_frame, rx_bad_frame}), 64'd0);
    check_stats(tag);
    repeat (4) @(negedge axi_aclk);
  endtask

  initial begin
    axi_resetn    = 1'b0;
    tx_start      = 1'b0;
    tx_data       = 64'd0;
    tx_data_valid = 8'd0;
    repeat (3) @(negedge axi_aclk);
    check("reset/tx_ack", 64'(tx_ack), 64'd0);
    check("reset/rx_data", rx_data, 64'd0);
    check("reset/rx_valid", 64'(rx_data_valid), 64'd0);
    check("reset/status", 64'({rx_good_frame, rx_bad_frame}), 64'd0);
    check_stats("reset");
    axi_resetn = 1'b1;
    repeat (2) @(negedge axi_aclk);

    // 64 bytes: 8 full words then a zero-valid terminator.
    run_frame("f64", 8, 8'hFF, 1'b0, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    // 61 bytes: 7 full words + 5 bytes.
    run_frame("f61", 8, 8'h1F, 1'b0, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    // 40 bytes (runt) and 1600 bytes (oversize).
    run_frame("f40", 5, 8'hFF, 1'b1, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    run_frame("f1600", 200, 8'hFF, 1'b1, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    // Length boundaries: 60 good, 59 bad, 1514 good, 1515 bad.
    run_frame("f60", 8, 8'h0F, 1'b0, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    run_frame("f59", 8, 8'h07, 1'b1, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    run_frame("f1514", 190, 8'h03, 1'b0, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    run_frame("f1515", 190, 8'h07, 1'b1, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    // Invalid valid pattern 8'h05 on word 5 ends the frame there.
    run_frame("f05_short", 5, 8'h05, 1'b1, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    // 66 bytes would be legal, so only the 8'h05 pattern makes it bad; 71 bytes with 8'h7F is good.
    run_frame("f05_len_ok", 9, 8'h05, 1'b1, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    run_frame("f7F", 9, 8'h7F, 1'b0, 1'b0, ACK_DELAY, 1'b0, 1'b0);
    // tx_start re-asserted during DATA: legal length but bad.
    run_frame("viol", 8, 8'hFF, 1'b1, 1'b0, ACK_DELAY, 1'b1, 1'b0);
    // Back-to-back: start held from the status cycle, next ack at status+1+IFG+ACK_DELAY.
    run_frame("b2b_a", 8, 8'hFF, 1'b0, 1'b0, ACK_DELAY, 1'b0, 1'b1);
    run_frame("b2b_b", 8, 8'hFF, 1'b0, 1'b1, 1 + IFG_CYCLES + ACK_DELAY, 1'b0, 1'b0);

    // Reset asserted while word 4 is presented.
    @(negedge axi_aclk);
    tx_start      = 1'b1;
    tx_data       = word(0);
    tx_data_valid = 8'hFF;
    begin
      int lat;
      lat = 0;
      do begin
        @(negedge axi_aclk);
        lat++;
      end while (!tx_ack && lat < 32);
      check("rst_mid/ack_latency", 64'(lat), 64'(ACK_DELAY));
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge axi_aclk);
      tx_start = 1'b0;
      tx_data  = word(i);
    end
    check("rst_mid/pre_rx_data", rx_data, word(3));
    axi_resetn = 1'b0;
    #1;
    check("rst_mid/rx_data", rx_data, 64'd0);
    check("rst_mid/rx_valid", 64'(rx_data_valid), 64'd0);
    check("rst_mid/tx_ack", 64'(tx_ack), 64'd0);
    check("rst_mid/status", 64'({rx_good_frame, rx_bad_frame}), 64'd0);
    n_frames = 0;
    n_bad    = 0;
    check_stats("rst_mid");
    @(negedge axi_aclk);
    axi_resetn    = 1'b1;
    tx_data       = 64'd0;
    tx_data_valid = 8'h00;
    seq++;
    for (int i = 0; i < 6; i++) begin
      @(negedge axi_aclk);
      check("rst_mid/no_status", 64'({rx_good_frame, rx_bad_frame}), 64'd0);
    end
    check_stats("rst_mid_after");
    run_frame("post_rst", 8, 8'hFF, 1'b0, 1'b0, ACK_DELAY, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
